// File: rtl/timer_dev.sv
// timer_dev
// -----------------------------------------------------------------------------
// Programmable countdown timer for the DEV0 slot of the CPU bridge. It exposes
// three word registers: CTRL, PRESET and COUNT. It raises an interrupt on
// HWInt[2] when the count reaches zero.
//
// Ports:
//   clk   in   1  system clock, all state changes on the rising edge
//   rst   in   1  synchronous active-high reset
//   addr  in   2  register select (bridge word address bits [3:2])
//   we    in   1  write enable, already qualified by the bridge decode
//   wd    in  32  write data
//   rd    out 32  combinational read data for the selected register
//   irq   out  1  interrupt request, high while in INT with CTRL.IM set
//
// Register map: 0 = CTRL {IM, MODE[1:0], EN}, 1 = PRESET, 2 = COUNT (read-only),
// 3 = reserved (reads 0).
//
// Configuration macro: TIMER_AUTORELOAD_EN
//   defined   -> CTRL.MODE = 01 selects auto-reload (one-cycle irq pulse, then
//                the timer reloads from PRESET and counts down again)
//   undefined -> MODE is hard-wired to 0 and the timer is always one-shot
// -----------------------------------------------------------------------------
module timer_dev (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] preset_q, preset_d;
    logic        en_q, en_d;
    logic        im_q, im_d;
    logic [1:0]  modeBits;
    logic        autoReload;

    logic ctrlWrite;
    logic presetWrite;

    assign ctrlWrite   = we && (addr == 2'd0);
    assign presetWrite = we && (addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
    logic [1:0] mode_q;

    // MODE is plain software state; only the value 01 means auto-reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 2'b00;
        end else if (ctrlWrite) begin
            mode_q <= wd[2:1];
        end
    end

    assign modeBits   = mode_q;
    assign autoReload = (mode_q == 2'b01);
`else
    // Without auto-reload support MODE does not exist in hardware.
    assign modeBits   = 2'b00;
    assign autoReload = 1'b0;
`endif

    // State and register file update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= 32'd0;
            preset_q <= 32'd0;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            preset_q <= preset_d;
            en_q     <= en_d;
            im_q     <= im_d;
        end
    end

    // Next-state logic. The hardware EN clear on one-shot expiry is applied
    // first, so a software CTRL write on the same edge overrides it.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        en_d     = en_q;
        im_d     = im_q;

        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = ST_INT;
                    if (!autoReload) begin
                        en_d = 1'b0;
                    end
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                // Auto-reload INT lasts one cycle; one-shot INT waits for software.
                if (autoReload) begin
                    state_d = ST_LOAD;
                end else if (ctrlWrite) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ctrlWrite) begin
            en_d = wd[0];
            im_d = wd[3];
        end
        if (presetWrite) begin
            preset_d = wd;
        end
    end

    // Zero-wait read path for the bridge.
    always_comb begin
        rd = 32'd0;
        case (addr)
            2'd0:    rd = {28'd0, im_q, modeBits, en_q};
            2'd1:    rd = preset_q;
            2'd2:    rd = count_q;
            default: rd = 32'd0;
        endcase
    end

    assign irq = (state_q == ST_INT) && im_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev
// -----------------------------------------------------------------------------
// Self-checking bench for timer_dev. It runs a table of per-cycle register
// vectors, then hand-written corner sequences, then randomized timer runs that
// are compared against closed-form expectations for count, irq and CTRL.
// -----------------------------------------------------------------------------
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int testsRun = 0;
    int testsFailed = 0;

`ifdef TIMER_AUTORELOAD_EN
    localparam bit AUTO_BUILD = 1'b1;
`else
    localparam bit AUTO_BUILD = 1'b0;
`endif

    timer_dev dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .irq  (irq)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [1:0]  chkAddr;
        logic [31:0] expRd;
        logic        expIrq;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Drive one write (or idle) cycle; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        wd   = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // Combinational read of one register, between edges.
    task automatic readReg(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        readReg(a, v);
        checkOutput(name, v, exp);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 32'd0);
        rst = 1'b0;
    endtask

    // Closed-form expectation for a run started by a CTRL write at edge N,
    // sampled after edge N+k (k >= 1). Pause writes EN=0 at edge N+kp.
    task automatic expectRun(input int p, input int k, input bit autoMode, input bit im,
                             input bit paused, input int kp,
                             output int expCount, output bit expIrq, output bit expEn);
        int j;
        if (paused && k >= kp) begin
            expCount = p - (kp - 2);
            expIrq   = 1'b0;
            expEn    = 1'b0;
        end else if (k == 1) begin
            expCount = 0;
            expIrq   = 1'b0;
            expEn    = 1'b1;
        end else if (autoMode) begin
            j = (k - 2) % (p + 3);
            expCount = (j <= p) ? p - j : 0;
            expIrq   = im && (j == p + 1);
            expEn    = 1'b1;
        end else begin
            expCount = (k - 2 <= p) ? p - (k - 2) : 0;
            expIrq   = im && (k >= p + 3);
            expEn    = (k < p + 3);
        end
    endtask

    initial begin
        logic [31:0] v;
        rst  = 1'b0;
        we   = 1'b0;
        addr = 2'd0;
        wd   = 32'd0;

        // ---------------- reset state ----------------
        doReset();
        checkReg("reset ctrl", 2'd0, 32'd0);
        checkReg("reset preset", 2'd1, 32'd0);
        checkReg("reset count", 2'd2, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);

        // ---------------- table-driven vectors ----------------
        vecs.push_back('{1'b1, 2'd1, 32'd3,    2'd1, 32'd3, 1'b0, "os preset"});
        vecs.push_back('{1'b1, 2'd0, 32'h9,    2'd0, 32'h9, 1'b0, "os ctrl N"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b0, "os load N+1"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd3, 1'b0, "os count N+2"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd2, 1'b0, "os count N+3"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd1, 1'b0, "os count N+4"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b0, "os count N+5"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd0, 32'h8, 1'b1, "os int N+6"});
        vecs.push_back('{1'b1, 2'd2, 32'd55,   2'd2, 32'd0, 1'b1, "count write ignored"});
        vecs.push_back('{1'b1, 2'd3, 32'hFF,   2'd3, 32'd0, 1'b1, "reserved write"});
        vecs.push_back('{1'b1, 2'd0, 32'd0,    2'd0, 32'd0, 1'b0, "ctrl clear drops irq"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b0, "idle after int"});
        vecs.push_back('{1'b1, 2'd1, 32'd0,    2'd1, 32'd0, 1'b0, "p0 preset"});
        vecs.push_back('{1'b1, 2'd0, 32'h9,    2'd0, 32'h9, 1'b0, "p0 ctrl N"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b0, "p0 load N+1"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd2, 32'd0, 1'b0, "p0 cnt N+2"});
        vecs.push_back('{1'b0, 2'd0, 32'd0,    2'd0, 32'h8, 1'b1, "p0 int N+3"});
        vecs.push_back('{1'b1, 2'd0, 32'd0,    2'd0, 32'd0, 1'b0, "p0 clear"});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].w, vecs[i].a, vecs[i].d);
            checkReg(vecs[i].name, vecs[i].chkAddr, vecs[i].expRd);
            checkOutput({vecs[i].name, " irq"}, {31'd0, irq}, {31'd0, vecs[i].expIrq});
        end

        // ---------------- reset mid-count ----------------
        doReset();
        applyStimulus(1'b1, 2'd1, 32'd5);
        applyStimulus(1'b1, 2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 2'd0, 32'd0);
        checkReg("pre-reset count", 2'd2, 32'd3);
        doReset();
        checkReg("midrst ctrl", 2'd0, 32'd0);
        checkReg("midrst preset", 2'd1, 32'd0);
        checkReg("midrst count", 2'd2, 32'd0);
        checkReg("midrst reserved", 2'd3, 32'd0);
        checkOutput("midrst irq", {31'd0, irq}, 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 2'd0, 32'd0);
        checkReg("midrst no count", 2'd2, 32'd0);

        // ---------------- masked interrupt ----------------
        applyStimulus(1'b1, 2'd1, 32'd3);
        applyStimulus(1'b1, 2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 2'd0, 32'd0);
            checkOutput("masked irq", {31'd0, irq}, 32'd0);
        end
        checkReg("masked count", 2'd2, 32'd0);
        checkReg("masked ctrl", 2'd0, 32'd0);

        // ---------------- pause ----------------
        doReset();
        applyStimulus(1'b1, 2'd1, 32'd10);
        applyStimulus(1'b1, 2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) applyStimulus(1'b0, 2'd0, 32'd0);
        checkReg("pause count before", 2'd2, 32'd6);
        applyStimulus(1'b1, 2'd0, 32'h8);
        checkReg("pause count at stop", 2'd2, 32'd5);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 2'd0, 32'd0);
        checkReg("pause count held", 2'd2, 32'd5);
        checkOutput("pause irq", {31'd0, irq}, 32'd0);

        // ---------------- MODE = 01 request ----------------
        doReset();
        applyStimulus(1'b1, 2'd1, 32'd2);
        applyStimulus(1'b1, 2'd0, 32'hB);
        checkReg("mode ctrl read", 2'd0, AUTO_BUILD ? 32'hB : 32'h9);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 2'd0, 32'd0);
            if (AUTO_BUILD) begin
                checkOutput($sformatf("auto irq k=%0d", k), {31'd0, irq},
                            {31'd0, (k >= 5 && (k - 5) % 5 == 0)});
                if (k >= 7 && (k - 7) % 5 == 0) checkReg("auto reload count", 2'd2, 32'd2);
            end else begin
                checkOutput($sformatf("noauto irq k=%0d", k), {31'd0, irq}, {31'd0, k >= 5});
                if (k == 6) checkReg("noauto ctrl", 2'd0, 32'h8);
            end
        end

        // ---------------- randomized runs ----------------
        for (int run = 0; run < 24; run++) begin
            int p, kp, expCount;
            bit im, paused, autoMode, expIrq, expEn;
            logic [1:0] mode, modeRead;
            p        = $urandom_range(0, 12);
            im       = 1'($urandom_range(0, 1));
            mode     = 2'($urandom_range(0, 3));
            autoMode = AUTO_BUILD && (mode == 2'b01);
            modeRead = AUTO_BUILD ? mode : 2'b00;
            paused   = !autoMode && (p >= 1) && ($urandom_range(0, 2) == 0);
            kp       = paused ? $urandom_range(3, p + 2) : 0;

            doReset();
            applyStimulus(1'b1, 2'd1, 32'(p));
            applyStimulus(1'b1, 2'd0, {28'd0, im, mode, 1'b1});
            for (int k = 1; k <= p + 10; k++) begin
                if (paused && k == kp) begin
                    applyStimulus(1'b1, 2'd0, {28'd0, im, mode, 1'b0});
                end else if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b1, 2'($urandom_range(2, 3)), $urandom);
                end else begin
                    applyStimulus(1'b0, 2'd0, 32'd0);
                end
                expectRun(p, k, autoMode, im, paused, kp, expCount, expIrq, expEn);
                readReg(2'd2, v);
                checkOutput($sformatf("rand%0d k=%0d count", run, k), v, 32'(expCount));
                checkOutput($sformatf("rand%0d k=%0d irq", run, k), {31'd0, irq}, {31'd0, expIrq});
                readReg(2'd0, v);
                checkOutput($sformatf("rand%0d k=%0d ctrl", run, k), v,
                            {28'd0, im, modeRead, expEn});
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
